// File: rtl/array_result_wr.sv
// Writeback stage: buffers accumulator results and issues one cache-line write per result.
// States: IDLE = waiting for start | RUN = capture and issue | DRAIN = awaiting acks | DONE = job complete
module array_result_wr #(
    parameter int CACHE_WIDTH = 512,
    parameter int ADDR_WIDTH  = 42,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [31:0]            num_results,
    input  logic [CACHE_WIDTH-1:0] res_data,
    input  logic                   res_valid,
    input  logic                   wr_almfull,
    output logic                   wr_valid,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [CACHE_WIDTH-1:0] wr_data,
    output logic [15:0]            wr_mdata,
    input  logic                   wr_rsp_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [31:0]            num_q, pushed_q, issued_q, acked_q;
    logic [CACHE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, rptr_q;
    logic [CW-1:0]          count_q;
    logic                   wr_valid_q, done_q, overflow_q;
    logic [ADDR_WIDTH-1:0]  wr_addr_q;
    logic [CACHE_WIDTH-1:0] wr_data_q;
    logic [15:0]            wr_mdata_q;

    logic start_acc, fifo_full, push_req, push, pop, drop, ack;

    always_comb begin
        start_acc = start && (state_q == S_IDLE || state_q == S_DONE);
        fifo_full = (count_q == CW'(FIFO_DEPTH));
        push_req  = (state_q == S_RUN) && res_valid && (pushed_q < num_q);
        pop       = (state_q == S_RUN) && (count_q != '0) && !wr_almfull && (issued_q < num_q);
        // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
        push      = push_req && (!fifo_full || pop);
        drop      = push_req && fifo_full && !pop;
        ack       = (state_q == S_RUN || state_q == S_DRAIN) && wr_rsp_valid && (acked_q < num_q);

        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (num_results == 32'd0) ? S_DONE : S_RUN;
            S_RUN:          if (issued_q == num_q) state_d = S_DRAIN;
            S_DRAIN:        if (acked_q == num_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            pushed_q   <= '0;
            issued_q   <= '0;
            acked_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_mdata_q <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_valid_q <= pop;
            if (start_acc) begin
                base_q     <= base_addr;
                num_q      <= num_results;
                pushed_q   <= '0;
                issued_q   <= '0;
                acked_q    <= '0;
                wptr_q     <= '0;
                rptr_q     <= '0;
                count_q    <= '0;
                done_q     <= 1'b0;
                overflow_q <= 1'b0;
            end else begin
                if (push) begin
                    wptr_q   <= wptr_q + PW'(1);
                    pushed_q <= pushed_q + 32'd1;
                end
                if (pop) begin
                    rptr_q     <= rptr_q + PW'(1);
                    issued_q   <= issued_q + 32'd1;
                    wr_addr_q  <= base_q + ADDR_WIDTH'(issued_q);
                    wr_data_q  <= mem_q[rptr_q];
                    wr_mdata_q <= issued_q[15:0];
                end
                count_q <= count_q + CW'(push) - CW'(pop);
                if (ack) acked_q <= acked_q + 32'd1;
                if (drop) overflow_q <= 1'b1;
                if (state_q == S_DONE) done_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= res_data;
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_mdata = wr_mdata_q;
    assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_array_result_wr.sv
// Directed bench for array_result_wr: hand-computed addresses, tags and data per job.
module tb_array_result_wr;

    logic         clk, rst, start, res_valid, wr_almfull;
    logic [41:0]  base_addr;
    logic [31:0]  num_results;
    logic [511:0] res_data;
    logic         wr_valid, busy, done, overflow;
    logic [41:0]  wr_addr;
    logic [511:0] wr_data;
    logic [15:0]  wr_mdata;
    logic         wr_rsp_valid;
    logic         man_rsp, auto_rsp;
    logic [4:0]   rsp_pipe;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [41:0]  qa [$];
    logic [511:0] qd [$];
    logic [15:0]  qm [$];
    int           qc [$];

    array_result_wr #(.CACHE_WIDTH(512), .ADDR_WIDTH(42), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_results(num_results), .res_data(res_data), .res_valid(res_valid),
        .wr_almfull(wr_almfull), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_mdata(wr_mdata), .wr_rsp_valid(wr_rsp_valid),
        .busy(busy), .done(done), .overflow(overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: one response 5 cycles after each observed write when enabled.
    always @(posedge clk) begin
        if (rst) rsp_pipe <= '0;
        else     rsp_pipe <= {rsp_pipe[3:0], wr_valid};
    end
    assign wr_rsp_valid = man_rsp | (auto_rsp & rsp_pipe[4]);

    always @(negedge clk) begin
        if (wr_valid) begin
            qa.push_back(wr_addr);
            qd.push_back(wr_data);
            qm.push_back(wr_mdata);
            qc.push_back(cyc);
        end
    end

    function automatic logic [511:0] mk(input int k);
        return {16{32'hC0DE_0000 + k}};
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [41:0] b, input logic [31:0] n);
        qa.delete(); qd.delete(); qm.delete(); qc.delete();
        base_addr = b;
        num_results = n;
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic send_res(input int k);
        res_data = mk(k);
        res_valid = 1;
        tick(1);
        res_valid = 0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc && !done; i++) tick(1);
    endtask

    task automatic wait_writes(input int n, input int maxc);
        for (int i = 0; i < maxc && qa.size() < n; i++) tick(1);
    endtask

    initial begin
        rst = 1; start = 0; res_valid = 0; wr_almfull = 0; man_rsp = 0; auto_rsp = 1;
        base_addr = '0; num_results = '0; res_data = '0;
        tick(3);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_flags", {busy, done, overflow}, 0);
        rst = 0;
        tick(1);

        // Job 1: spaced results, responses 5 cycles after each write
        start_job(42'h100, 3);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 3; i++) begin
            send_res(i);
            tick(3);
        end
        wait_done(60);
        chk("t1_done", done, 1);
        chk("t1_busy_fall", busy, 0);
        chk("t1_nwrites", qa.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_addr%0d", i), qa[i], 42'h100 + i);
            chk($sformatf("t1_data%0d", i), qd[i], mk(i));
            chk($sformatf("t1_mdata%0d", i), qm[i], i);
        end
        chk("t1_addr_hold", wr_addr, 42'h102);
        chk("t1_ovf", overflow, 0);

        // Job 2: almost-full hold, then back-to-back issue
        wr_almfull = 1;
        start_job(42'h200, 4);
        for (int i = 0; i < 4; i++) send_res(16 + i);
        tick(5);
        chk("t2_no_wr_in_hold", qa.size(), 0);
        wr_almfull = 0;
        wait_writes(4, 20);
        chk("t2_nwrites", qa.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_addr%0d", i), qa[i], 42'h200 + i);
            chk($sformatf("t2_data%0d", i), qd[i], mk(16 + i));
        end
        for (int i = 0; i < 3; i++) chk($sformatf("t2_b2b%0d", i), qc[i + 1] - qc[i], 1);
        chk("t2_ovf", overflow, 0);
        wait_done(40);
        chk("t2_done", done, 1);

        // Job 3: overflow on a 4-deep FIFO
        wr_almfull = 1;
        start_job(42'h300, 6);
        for (int i = 0; i < 6; i++) send_res(32 + i);
        tick(1);
        chk("t3_ovf", overflow, 1);
        wr_almfull = 0;
        tick(10);
        chk("t3_nwrites", qa.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t3_data%0d", i), qd[i], mk(32 + i));
        chk("t3_still_run", {busy, done}, 2'b10);
        send_res(40);
        send_res(41);
        wait_writes(6, 20);
        chk("t3_nwrites2", qa.size(), 6);
        chk("t3_addr5", qa[5], 42'h305);
        chk("t3_data5", qd[5], mk(41));
        wait_done(40);
        chk("t3_done", done, 1);
        chk("t3_ovf_sticky", overflow, 1);

        // Job 4: zero-length job
        start_job(42'h400, 0);
        chk("t4_done_clr", done, 0);
        chk("t4_ovf_clr", overflow, 0);
        tick(1);
        chk("t4_done", done, 1);
        for (int i = 0; i < 3; i++) send_res(48 + i);
        tick(5);
        chk("t4_no_wr", qa.size(), 0);
        chk("t4_state", {busy, done}, 2'b01);

        // Job 5: address wrap
        start_job(42'h3FF_FFFF_FFFF, 2);
        send_res(56);
        send_res(57);
        wait_done(40);
        chk("t5_done", done, 1);
        chk("t5_nwrites", qa.size(), 2);
        chk("t5_addr0", qa[0], 42'h3FF_FFFF_FFFF);
        chk("t5_addr1", qa[1], 42'h0);
        chk("t5_mdata1", qm[1], 1);

        // Job 6: reset during DRAIN with one ack outstanding
        auto_rsp = 0;
        start_job(42'h500, 2);
        send_res(64);
        send_res(65);
        wait_writes(2, 20);
        tick(2);
        man_rsp = 1;
        tick(1);
        man_rsp = 0;
        tick(1);
        chk("t6_drain", {busy, done}, 2'b10);
        rst = 1;
        tick(1);
        chk("t6_rst_wr_valid", wr_valid, 0);
        chk("t6_rst_wr_addr", wr_addr, 0);
        chk("t6_rst_wr_data", wr_data, 0);
        chk("t6_rst_wr_mdata", wr_mdata, 0);
        chk("t6_rst_flags", {busy, done, overflow}, 0);
        rst = 0;
        man_rsp = 1;
        tick(1);
        man_rsp = 0;
        tick(3);
        chk("t6_late_rsp", {busy, done}, 0);
        auto_rsp = 1;
        start_job(42'h600, 1);
        send_res(72);
        wait_done(40);
        chk("t6_new_done", done, 1);
        chk("t6_new_nwrites", qa.size(), 1);
        chk("t6_new_addr", qa[0], 42'h600);
        chk("t6_new_data", qd[0], mk(72));
        chk("t6_new_mdata", qm[0], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
